// File: rtl/puzzle_pkg.sv
// Shared encodings and width helpers for the sliding-tile puzzle engine.
package puzzle_pkg;

  typedef enum logic [1:0] {
    GS_CHOOSE = 2'b00,
    GS_GAMING = 2'b01,
    GS_INIT   = 2'b10,
    GS_WON    = 2'b11
  } game_status_e;

  localparam int ACT_UP    = 0;
  localparam int ACT_RIGHT = 1;
  localparam int ACT_DOWN  = 2;
  localparam int ACT_LEFT  = 3;

  // Tile code is wide enough for every index plus a dedicated blank bit.
  function automatic int calc_tw(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int calc_blank(input int tw);
    return 1 << (tw - 1);
  endfunction

endpackage

// File: rtl/puzzle_solved_chk.sv
// Registered solved detector: every cell holds its own index or the blank,
// with exactly one blank on the board.
module puzzle_solved_chk
  import puzzle_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  localparam int N  = ROWS * COLS,
  localparam int TW = calc_tw(ROWS * COLS)
) (
  input  logic            clk_d,
  input  logic            reset,
  input  logic [N*TW-1:0] board,
  output logic            win_flag
);

  localparam logic [TW-1:0] BLANK_T = TW'(calc_blank(TW));

  logic solved;

  always_comb begin
    int   blanks;
    logic order_ok;
    blanks   = 0;
    order_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (board[(N-1-i)*TW +: TW] == BLANK_T) blanks = blanks + 1;
      else if (board[(N-1-i)*TW +: TW] != TW'(i)) order_ok = 1'b0;
    end
    solved = order_ok && (blanks == 1);
  end

  always_ff @(posedge clk_d) begin
    if (reset) win_flag <= 1'b0;
    else       win_flag <= solved;
  end

endmodule

// File: rtl/puzzle_engine.sv
// Sliding-tile puzzle engine: loads a start board, applies blank moves with
// edge rejection, counts legal moves and reports the solved state.
module puzzle_engine
  import puzzle_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int COLS      = 2,
  parameter int START_POS = 2,
  parameter int CW        = 8,
  localparam int N  = ROWS * COLS,
  localparam int TW = calc_tw(ROWS * COLS),
  localparam int PW = $clog2(ROWS * COLS)
) (
  input  logic            clk_d,
  input  logic            reset,
  input  logic [1:0]      game_status,
  input  logic            restart,
  input  logic [3:0]      act,
  input  logic [N*TW-1:0] origin_board,
  output logic [N*TW-1:0] board,
  output logic [PW-1:0]   blank_pos,
  output logic [CW-1:0]   move_cnt,
  output logic            move_ok,
  output logic            illegal,
  output logic            win_flag
);

  localparam logic [TW-1:0] BLANK_T = TW'(calc_blank(TW));

  logic [N*TW-1:0] shadow;
  logic [N*TW-1:0] ident_board;
  logic [N*TW-1:0] load_board;
  logic [N*TW-1:0] moved_board;
  logic [N*TW-1:0] blank_board;
  logic            one_hot;
  logic            move_legal;
  logic [PW-1:0]   nb_pos;

  always_comb begin
    ident_board = '0;
    blank_board = '0;
    for (int i = 0; i < N; i++) begin
      ident_board[(N-1-i)*TW +: TW] = TW'(i);
      blank_board[(N-1-i)*TW +: TW] = BLANK_T;
    end
  end

  always_comb begin
    load_board = shadow;
    load_board[(N-1-START_POS)*TW +: TW] = BLANK_T;
  end

  // Row/column of the blank decide which directions leave the board.
  always_comb begin
    int bp;
    int row;
    int col;
    bp         = int'(blank_pos);
    row        = bp / COLS;
    col        = bp % COLS;
    one_hot    = (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
    move_legal = 1'b0;
    nb_pos     = blank_pos;
    if (one_hot) begin
      if (act[ACT_UP] && row != 0) begin
        move_legal = 1'b1;
        nb_pos     = PW'(bp - COLS);
      end
      if (act[ACT_DOWN] && row != ROWS - 1) begin
        move_legal = 1'b1;
        nb_pos     = PW'(bp + COLS);
      end
      if (act[ACT_LEFT] && col != 0) begin
        move_legal = 1'b1;
        nb_pos     = PW'(bp - 1);
      end
      if (act[ACT_RIGHT] && col != COLS - 1) begin
        move_legal = 1'b1;
        nb_pos     = PW'(bp + 1);
      end
    end
  end

  always_comb begin
    logic [TW-1:0] nb_tile;
    nb_tile = BLANK_T;
    for (int i = 0; i < N; i++) begin
      if (i == int'(nb_pos)) nb_tile = board[(N-1-i)*TW +: TW];
    end
    moved_board = board;
    for (int i = 0; i < N; i++) begin
      if (i == int'(blank_pos))   moved_board[(N-1-i)*TW +: TW] = nb_tile;
      else if (i == int'(nb_pos)) moved_board[(N-1-i)*TW +: TW] = BLANK_T;
    end
  end

  always_ff @(posedge clk_d) begin
    if (reset) begin
      board     <= blank_board;
      shadow    <= ident_board;
      blank_pos <= PW'(START_POS);
      move_cnt  <= '0;
      move_ok   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      move_ok <= 1'b0;
      illegal <= 1'b0;
      case (game_status_e'(game_status))
        GS_CHOOSE: shadow <= origin_board;
        GS_INIT: begin
          board     <= load_board;
          blank_pos <= PW'(START_POS);
          move_cnt  <= '0;
        end
        GS_GAMING: begin
          if (restart) begin
            board     <= load_board;
            blank_pos <= PW'(START_POS);
            move_cnt  <= '0;
          end else if (act != 4'd0) begin
            if (move_legal) begin
              board     <= moved_board;
              blank_pos <= nb_pos;
              move_ok   <= 1'b1;
              if (move_cnt != {CW{1'b1}}) move_cnt <= move_cnt + 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        GS_WON: shadow <= ident_board;
        default: ;
      endcase
    end
  end

  puzzle_solved_chk #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_solved_chk (
    .clk_d   (clk_d),
    .reset   (reset),
    .board   (board),
    .win_flag(win_flag)
  );

endmodule
